// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mips_pipe_pkg                                                 |
// | Purpose  : Shared widths, constants and types for the MIPS pipeline      |
// |            front end (fetch stage and IF/ID pipeline register).          |
// | Contents : WORD_W, NOP_INSTR, DEFAULT_RESET_PC, STALL_CNT_W,             |
// |            if_id_t payload struct, pc_plus4() helper.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package mips_pipe_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned STALL_CNT_W = 16;

  localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } if_id_t;

  // Sequential PC increment; the 32-bit add wraps naturally modulo 2^32.
  function automatic logic [WORD_W-1:0] pc_plus4(input logic [WORD_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : if_id_reg                                                     |
// | Purpose  : IF/ID pipeline register holding instruction, PC+4 and valid.  |
// |            Per-edge priority: reset > flush > hold > load.               |
// | Ports    : clk, reset (sync, active-low)                                 |
// |            i_flush     - squash contents to a NOP bubble                 |
// |            i_hold      - keep current contents                           |
// |            i_instr     - instruction to load                             |
// |            i_pc_plus4  - PC+4 of that instruction                        |
// |            o_instr, o_pc_plus4, o_valid - registered outputs             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module if_id_reg
  import mips_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic [WORD_W-1:0] i_instr,
  input  logic [WORD_W-1:0] i_pc_plus4,
  output logic [WORD_W-1:0] o_instr,
  output logic [WORD_W-1:0] o_pc_plus4,
  output logic              o_valid
);

  localparam if_id_t c_bubble = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= c_bubble;
    end else if (i_flush) begin
      r_q <= c_bubble;
    end else if (!i_hold) begin
      r_q <= '{instr: i_instr, pc_plus4: i_pc_plus4, valid: 1'b1};
    end
  end

  assign o_instr    = r_q.instr;
  assign o_pc_plus4 = r_q.pc_plus4;
  assign o_valid    = r_q.valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_stage                                                   |
// | Purpose  : Instruction fetch stage: PC register, next-PC selection and   |
// |            the IF/ID pipeline register.                                  |
// | Params   : RESET_PC - PC loaded while reset is low                       |
// | Macro    : FETCH_STALL_COUNT_EN - adds saturating stall counter and the  |
// |            Stall_Count_Out port                                          |
// | Ports    : clk, reset (sync, active-low)                                 |
// |            PC_Freeze_In, IF_ID_Stall_Write_In - hazard unit holds        |
// |            Branch_Taken_In, Branch_Target_In  - EX-stage redirect        |
// |            Instr_Mem_Data_In / Instr_Mem_Addr_Out - instruction memory   |
// |            ID_Instruction_Out, ID_PC_Plus4_Out, ID_Valid_Out - to ID     |
// |            Stall_Count_Out - stall-cycle counter (macro only)            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fetch_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Freeze_In,
  input  logic        IF_ID_Stall_Write_In,
  input  logic        Branch_Taken_In,
  input  logic [31:0] Branch_Target_In,
  input  logic [31:0] Instr_Mem_Data_In,
  output logic [31:0] Instr_Mem_Addr_Out,
  output logic [31:0] ID_Instruction_Out,
  output logic [31:0] ID_PC_Plus4_Out,
  output logic        ID_Valid_Out
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [15:0] Stall_Count_Out
`endif
);

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_pc_plus4;
  logic [WORD_W-1:0] w_pc_next;

  assign w_pc_plus4 = pc_plus4(r_pc);

  // Redirect targets are forced word-aligned; a redirect overrides a freeze.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (Branch_Taken_In) begin
      w_pc_next = {Branch_Target_In[31:2], 2'b00};
    end else if (PC_Freeze_In) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign Instr_Mem_Addr_Out = r_pc;

  // The branch flush wins over the hazard unit's stall request.
  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (Branch_Taken_In),
    .i_hold     (IF_ID_Stall_Write_In),
    .i_instr    (Instr_Mem_Data_In),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (ID_Instruction_Out),
    .o_pc_plus4 (ID_PC_Plus4_Out),
    .o_valid    (ID_Valid_Out)
  );

`ifdef FETCH_STALL_COUNT_EN
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Counts only edges where the IF/ID register actually held; a flush edge
  // is not a stall even if the hazard unit asked for one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (IF_ID_Stall_Write_In && !Branch_Taken_In && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign Stall_Count_Out = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                                |
// | Purpose  : Self-checking bench for fetch_stage. Directed vectors push    |
// |            their expected post-edge state into a queue; a monitor pops   |
// |            and compares after every rising edge.                         |
// | Macro    : FETCH_STALL_COUNT_EN - also checks Stall_Count_Out            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PC_Freeze_In = 1'b0;
  logic        IF_ID_Stall_Write_In = 1'b0;
  logic        Branch_Taken_In = 1'b0;
  logic [31:0] Branch_Target_In = 32'h0;
  logic [31:0] Instr_Mem_Data_In;
  logic [31:0] Instr_Mem_Addr_Out;
  logic [31:0] ID_Instruction_Out;
  logic [31:0] ID_PC_Plus4_Out;
  logic        ID_Valid_Out;
  logic [15:0] Stall_Count_Out;

  always #5 clk = ~clk;

  // Instruction memory stand-in: each word is tagged with its own address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {16'hC0DE, a[15:0]} ^ {a[31:16], 16'h0000};
  endfunction

  assign Instr_Mem_Data_In = imem(Instr_Mem_Addr_Out);

  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk                  (clk),
    .reset                (reset),
    .PC_Freeze_In         (PC_Freeze_In),
    .IF_ID_Stall_Write_In (IF_ID_Stall_Write_In),
    .Branch_Taken_In      (Branch_Taken_In),
    .Branch_Target_In     (Branch_Target_In),
    .Instr_Mem_Data_In    (Instr_Mem_Data_In),
    .Instr_Mem_Addr_Out   (Instr_Mem_Addr_Out),
    .ID_Instruction_Out   (ID_Instruction_Out),
    .ID_PC_Plus4_Out      (ID_PC_Plus4_Out),
    .ID_Valid_Out         (ID_Valid_Out)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .Stall_Count_Out      (Stall_Count_Out)
`endif
  );

`ifndef FETCH_STALL_COUNT_EN
  assign Stall_Count_Out = 16'h0;
`endif

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: one expected state per rising edge once stimulus has started.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "pc",    Instr_Mem_Addr_Out, e.pc);
      chk(e.name, "instr", ID_Instruction_Out, e.instr);
      chk(e.name, "pc4",   ID_PC_Plus4_Out,    e.pc4);
      chk(e.name, "valid", {31'b0, ID_Valid_Out}, {31'b0, e.valid});
`ifdef FETCH_STALL_COUNT_EN
      chk(e.name, "cnt",   {16'b0, Stall_Count_Out}, {16'b0, e.cnt});
`endif
    end
  end

  // Drive one cycle of inputs and record the state expected after the edge.
  task automatic step(input string nm, input logic rst_n, input logic fz, input logic st,
                      input logic br, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pc4, input logic e_valid, input logic [15:0] e_cnt);
    exp_t e;
    @(negedge clk);
    reset                = rst_n;
    PC_Freeze_In         = fz;
    IF_ID_Stall_Write_In = st;
    Branch_Taken_In      = br;
    Branch_Target_In     = tgt;
    e.name = nm; e.pc = e_pc; e.instr = e_instr; e.pc4 = e_pc4; e.valid = e_valid; e.cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    // Reset low for two edges.
    step("rst0", 0, 0, 0, 0, 32'h0, 32'h0040_0000, 32'h0, 32'h0, 0, 16'd0);
    step("rst1", 0, 0, 0, 0, 32'h0, 32'h0040_0000, 32'h0, 32'h0, 0, 16'd0);
    // First fetch from RESET_PC.
    step("first", 1, 0, 0, 0, 32'h0, 32'h0040_0004, imem(32'h0040_0000), 32'h0040_0004, 1, 16'd0);
    // Redirect to 0xC, then one sequential fetch brings PC to 0x10.
    step("br_c",  1, 0, 0, 1, 32'h0000_000C, 32'h0000_000C, 32'h0, 32'h0, 0, 16'd0);
    step("seq_c", 1, 0, 0, 0, 32'h0, 32'h0000_0010, imem(32'h0000_000C), 32'h0000_0010, 1, 16'd0);
    // Freeze + stall two cycles at PC 0x10.
    step("hold1", 1, 1, 1, 0, 32'h0, 32'h0000_0010, imem(32'h0000_000C), 32'h0000_0010, 1, 16'd1);
    step("hold2", 1, 1, 1, 0, 32'h0, 32'h0000_0010, imem(32'h0000_000C), 32'h0000_0010, 1, 16'd2);
    step("resume", 1, 0, 0, 0, 32'h0, 32'h0000_0014, imem(32'h0000_0010), 32'h0000_0014, 1, 16'd2);
    // Freeze alone: PC held, IF/ID still loads.
    step("fz_only", 1, 1, 0, 0, 32'h0, 32'h0000_0014, imem(32'h0000_0014), 32'h0000_0018, 1, 16'd2);
    // Stall alone: PC advances, IF/ID held.
    step("st_only", 1, 0, 1, 0, 32'h0, 32'h0000_0018, imem(32'h0000_0014), 32'h0000_0018, 1, 16'd3);
    // Branch beats freeze+stall; target low bits cleared; counter unchanged.
    step("br_prio", 1, 1, 1, 1, 32'h0000_0203, 32'h0000_0200, 32'h0, 32'h0, 0, 16'd3);
    step("seq_200", 1, 0, 0, 0, 32'h0, 32'h0000_0204, imem(32'h0000_0200), 32'h0000_0204, 1, 16'd3);
    // Wrap-around from the top of the address space.
    step("br_top", 1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 16'd3);
    step("wrap",   1, 0, 0, 0, 32'h0, 32'h0000_0000, imem(32'hFFFF_FFFC), 32'h0000_0000, 1, 16'd3);
    // Build counter up to 5 with stall only, then reset mid-stall and mid-redirect.
    step("st4", 1, 0, 1, 0, 32'h0, 32'h0000_0004, imem(32'hFFFF_FFFC), 32'h0000_0000, 1, 16'd4);
    step("st5", 1, 0, 1, 0, 32'h0, 32'h0000_0008, imem(32'hFFFF_FFFC), 32'h0000_0000, 1, 16'd5);
    step("rst_mid", 0, 1, 1, 1, 32'h0000_0100, 32'h0040_0000, 32'h0, 32'h0, 0, 16'd0);
    step("refetch", 1, 0, 0, 0, 32'h0, 32'h0040_0004, imem(32'h0040_0000), 32'h0040_0004, 1, 16'd0);
`ifdef FETCH_STALL_COUNT_EN
    // Long freeze+stall: counter saturates at 0xFFFF.
    for (int i = 1; i <= 70000; i++) begin
      step("sat", 1, 1, 1, 0, 32'h0, 32'h0040_0004, imem(32'h0040_0000), 32'h0040_0004, 1,
           (i > 65535) ? 16'hFFFF : i[15:0]);
    end
`endif
    // Let the monitor drain the final expectation.
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the stimulus never waits on the DUT, but guard against hangs.
  initial begin
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog actual=timeout required=completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 PC_Freeze_In  input  1  hazard unit: hold PC this cycle.
REQ-005 IF_ID_Stall_Write_In  input  1  hazard unit: hold IF/ID register this cycle.
REQ-006 Branch_Taken_In  input  1  EX-stage redirect request.
REQ-007 Branch_Target_In  input  32  redirect address.
REQ-008 Instr_Mem_Data_In  input  32  instruction memory read data for Instr_Mem_Addr_Out, valid same cycle.
REQ-009 Instr_Mem_Addr_Out  output  32  current PC, driven combinationally from PC register.
REQ-010 ID_Instruction_Out  output  32  registered instruction to ID stage.
REQ-011 ID_PC_Plus4_Out  output  32  registered PC+4 of that instruction.
REQ-012 ID_Valid_Out  output  1  1 = ID outputs carry a real instruction.
REQ-013 Stall_Count_Out  output  16  stall-cycle counter (present only under FETCH_STALL_COUNT_EN).

Function
REQ-014 Next-PC priority per edge: Branch_Taken_In -> {Branch_Target_In[31:2],2'b00}; else PC_Freeze_In -> hold; else PC+4.
REQ-015 PC+4 wraps modulo 2^32: 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-016 IF/ID priority per edge: Branch_Taken_In -> flush (instruction 32'h0000_0000, PC+4 field 0, valid 0); else IF_ID_Stall_Write_In -> hold all three fields; else load Instr_Mem_Data_In, PC+4, valid 1.
REQ-017 Branch takes priority over simultaneous freeze/stall; both PC redirect and flush occur that edge.
REQ-018 Latency: instruction at PC during cycle n appears on ID outputs in cycle n+1; redirect target fetched in cycle n+1, delivered in n+2.
REQ-019 PC_Freeze_In and IF_ID_Stall_Write_In are honoured independently; no cross-checking (stall without freeze drops the fetched instruction, by design of the hazard unit contract).
REQ-020 No combinational path from any input to ID_* outputs.

Reset
REQ-021 reset=0 at an edge overrides all other inputs, including mid-stall or mid-redirect.
REQ-022 Reset values: PC=RESET_PC, ID_Instruction_Out=0, ID_PC_Plus4_Out=0, ID_Valid_Out=0, Stall_Count_Out=0.
REQ-023 First fetch from RESET_PC occurs in the first cycle after reset deasserts.

Configuration
REQ-024 Macro FETCH_STALL_COUNT_EN defined: Stall_Count_Out counts edges with IF_ID_Stall_Write_In=1 and Branch_Taken_In=0, saturating at 16'hFFFF; cleared only by reset.
REQ-025 Macro undefined: counter logic and Stall_Count_Out port absent; all other behaviour identical.

Structure
REQ-026 Shared package mips_pipe_pkg holds: WORD_W=32, NOP_INSTR=32'h0000_0000, default RESET_PC, STALL_CNT_W=16.
REQ-027 One sub-module if_id_reg (instruction, PC+4, valid with hold/flush/load priority); PC logic stays in fetch_stage.

Verification
REQ-028 Reset low 2 cycles, RESET_PC=0x0040_0000, release -> Instr_Mem_Addr_Out=0x0040_0000, ID_Valid_Out=0, next cycle ID_PC_Plus4_Out=0x0040_0004, valid 1.
REQ-029 Freeze+stall high 2 cycles at PC=0x10 -> PC stays 0x10, ID outputs unchanged 2 cycles, resumes 0x14 after release; counter (if enabled) =2.
REQ-030 Branch_Taken_In=1, target 0x0000_0203, concurrent freeze+stall -> PC=0x0000_0200, ID_Valid_Out=0, ID_Instruction_Out=0, counter unchanged.
REQ-031 PC=0xFFFF_FFFC, no stall -> next PC=0x0000_0000, ID_PC_Plus4_Out=0x0000_0000, valid 1.
REQ-032 reset=0 asserted during active stall with counter=5 -> all REQ-022 values next edge, counter 0.
REQ-033 Stall held 70000 cycles with macro defined -> Stall_Count_Out saturates at 0xFFFF.
